imm_gen_pipe: RTL and testbench

- Parametrised, pipelined immediate generator for the decode stage.
- Extracts and extends the immediate from a 32-bit RISC-V instruction into an XLEN-wide value.
- Supports I/S/B/J/U formats plus CSR zimm and shift-amount modes.
- Registered output behind a valid/ready handshake with a 2-entry skid buffer, a synchronous flush, and a sticky illegal-select flag.

---
 rtl/imm_pkg.sv | 13 +
 rtl/imm_decode.sv | 35 +++
 rtl/imm_gen_pipe.sv | 71 +++++++
 tb/tb_imm_gen_pipe.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared encodings for the decode-stage immediate generator.
package imm_pkg;
  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] IMM_I     = 3'b000;
  localparam logic [SEL_W-1:0] IMM_S     = 3'b001;
  localparam logic [SEL_W-1:0] IMM_B     = 3'b010;
  localparam logic [SEL_W-1:0] IMM_J     = 3'b011;
  localparam logic [SEL_W-1:0] IMM_U     = 3'b100;
  localparam logic [SEL_W-1:0] IMM_Z     = 3'b101;
  localparam logic [SEL_W-1:0] IMM_SHAMT = 3'b110;
  localparam logic [SEL_W-1:0] IMM_RSVD  = 3'b111;
endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction/extension for one RISC-V instruction word.
module imm_decode #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 3
) (
  input  logic [31:0]      instr,
  input  logic [SEL_W-1:0] sel,
  output logic [XLEN-1:0]  value,
  output logic             rsvd
);
  import imm_pkg::*;

  logic [31:0] v32;
  logic        sx;

  // Build the 32-bit form first, then widen: sign formats replicate instr[31].
  always_comb begin
    v32  = '0;
    sx   = 1'b0;
    rsvd = 1'b0;
    case (sel)
      IMM_I:     begin v32 = {{20{instr[31]}}, instr[31:20]};                          sx = 1'b1; end
      IMM_S:     begin v32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};             sx = 1'b1; end
      IMM_B:     begin v32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};                                      sx = 1'b1; end
      IMM_J:     begin v32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};                                     sx = 1'b1; end
      IMM_U:     begin v32 = {instr[31:12], 12'b0};                                    sx = 1'b1; end
      IMM_Z:     v32 = {27'b0, instr[19:15]};
      IMM_SHAMT: v32 = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
      default:   rsvd = 1'b1;
    endcase
    value = sx ? XLEN'($signed(v32)) : XLEN'(v32);
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: 1-cycle latency, output reg + skid reg behind valid/ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic [31:0]      INSTR,
  input  logic [SEL_W-1:0] IMMSrc,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [XLEN-1:0]  IMMExt,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             ILLEGAL
);
  import imm_pkg::*;

  logic [XLEN-1:0] dec_val, out_q, skid_q;
  logic            dec_rsvd, out_vld, skid_full, ill_q;
  logic            acc, otx, out_free;

  imm_decode #(.XLEN(XLEN), .SEL_W(SEL_W)) u_dec (
    .instr (INSTR),
    .sel   (IMMSrc),
    .value (dec_val),
    .rsvd  (dec_rsvd)
  );

  // IN_READY comes straight from a flop, so OUT_READY never reaches it combinationally.
  assign IN_READY  = !skid_full;
  assign acc       = IN_VALID && IN_READY;
  assign otx       = out_vld && OUT_READY;
  assign out_free  = !out_vld || otx;
  assign IMMExt    = out_q;
  assign OUT_VALID = out_vld;
  assign ILLEGAL   = ill_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q     <= '0;
      skid_q    <= '0;
      out_vld   <= 1'b0;
      skid_full <= 1'b0;
      ill_q     <= 1'b0;
    end else if (FLUSH) begin
      out_vld   <= 1'b0;
      skid_full <= 1'b0;
    end else begin
      if (acc && dec_rsvd) ill_q <= 1'b1;
      if (out_free) begin
        // Skid holds the older word, so it drains first; a new word backfills skid.
        if (skid_full) begin
          out_q     <= skid_q;
          out_vld   <= 1'b1;
          skid_full <= acc;
          if (acc) skid_q <= dec_val;
        end else if (acc) begin
          out_q   <= dec_val;
          out_vld <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (acc) begin
        skid_q    <= dec_val;
        skid_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64 instances).
module tb_imm_gen_pipe;
  logic        CLK = 1'b0;
  logic        RST, FLUSH;
  logic [31:0] INSTR;
  logic [2:0]  IMMSrc;
  logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY, ILLEGAL;
  logic [31:0] IMMExt;

  logic [31:0] w_instr;
  logic [2:0]  w_sel;
  logic        w_in_valid, w_in_ready, w_out_valid, w_illegal;
  logic [63:0] w_imm;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  imm_gen_pipe #(.XLEN(32), .SEL_W(3)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .INSTR(INSTR), .IMMSrc(IMMSrc),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IMMExt(IMMExt),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ILLEGAL(ILLEGAL)
  );

  imm_gen_pipe #(.XLEN(64), .SEL_W(3)) dut64 (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .INSTR(w_instr), .IMMSrc(w_sel),
    .IN_VALID(w_in_valid), .IN_READY(w_in_ready), .IMMExt(w_imm),
    .OUT_VALID(w_out_valid), .OUT_READY(1'b1), .ILLEGAL(w_illegal)
  );

  task automatic test_reset();
    RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; INSTR = '0; IMMSrc = '0; OUT_READY = 1'b1;
    w_in_valid = 1'b0; w_instr = '0; w_sel = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
    n_checks++; if (IMMExt !== 32'h0) begin n_fail++; $display("FAIL reset_immext got %h want 0", IMMExt); end
    n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", IN_READY); end
    n_checks++; if (ILLEGAL !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", ILLEGAL); end
  endtask

  task automatic test_formats32();
    logic [31:0] ins [5] = '{32'hFFF00093, 32'hFE20AE23, 32'h00000463, 32'h0010006F, 32'h123450B7};
    logic [2:0]  sel [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h00000800, 32'h12345000};
    OUT_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      INSTR = ins[i]; IMMSrc = sel[i]; IN_VALID = 1'b1;
      @(negedge CLK);
      n_checks++; if (OUT_VALID !== 1'b1 || IMMExt !== exp[i]) begin
        n_fail++; $display("FAIL fmt32[%0d] got v=%b %h want v=1 %h", i, OUT_VALID, IMMExt, exp[i]);
      end
    end
    IN_VALID = 1'b0;
    @(negedge CLK);
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL fmt32_drain got %b want 0", OUT_VALID); end
  endtask

  task automatic test_xlen64();
    logic [31:0] ins [3] = '{32'h80000037, 32'h03F01013, 32'h000F5073};
    logic [2:0]  sel [3] = '{3'b100, 3'b110, 3'b101};
    logic [63:0] exp [3] = '{64'hFFFFFFFF80000000, 64'h3F, 64'h1E};
    for (int i = 0; i < 3; i++) begin
      w_instr = ins[i]; w_sel = sel[i]; w_in_valid = 1'b1;
      @(negedge CLK);
      n_checks++; if (w_out_valid !== 1'b1 || w_imm !== exp[i]) begin
        n_fail++; $display("FAIL fmt64[%0d] got v=%b %h want v=1 %h", i, w_out_valid, w_imm, exp[i]);
      end
    end
    w_in_valid = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    OUT_READY = 1'b0; IMMSrc = 3'b000;
    INSTR = 32'h00100093; IN_VALID = 1'b1;            // A -> 1
    @(negedge CLK);
    n_checks++; if (OUT_VALID !== 1'b1 || IMMExt !== 32'd1 || IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL bp_a got v=%b %h rdy=%b want v=1 1 rdy=1", OUT_VALID, IMMExt, IN_READY);
    end
    INSTR = 32'h00200093;                             // B -> 2, lands in skid
    @(negedge CLK);
    n_checks++; if (IN_READY !== 1'b0 || IMMExt !== 32'd1) begin
      n_fail++; $display("FAIL bp_full got rdy=%b %h want rdy=0 1", IN_READY, IMMExt);
    end
    INSTR = 32'h00300093;                             // C -> 3, held off
    @(negedge CLK);
    n_checks++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || IMMExt !== 32'd1) begin
      n_fail++; $display("FAIL bp_hold got rdy=%b v=%b %h want rdy=0 v=1 1", IN_READY, OUT_VALID, IMMExt);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    n_checks++; if (OUT_VALID !== 1'b1 || IMMExt !== 32'd2 || IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL bp_b got v=%b %h rdy=%b want v=1 2 rdy=1", OUT_VALID, IMMExt, IN_READY);
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    n_checks++; if (OUT_VALID !== 1'b1 || IMMExt !== 32'd3) begin
      n_fail++; $display("FAIL bp_c got v=%b %h want v=1 3", OUT_VALID, IMMExt);
    end
    @(negedge CLK);
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", OUT_VALID); end
  endtask

  task automatic test_flush();
    OUT_READY = 1'b0; IMMSrc = 3'b000; IN_VALID = 1'b1;
    INSTR = 32'h00500093; @(negedge CLK);
    INSTR = 32'h00600093; @(negedge CLK);
    INSTR = 32'h00700093; FLUSH = 1'b1; @(negedge CLK);
    FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    n_checks++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL flush got v=%b rdy=%b want v=0 rdy=1", OUT_VALID, IN_READY);
    end
    repeat (2) @(negedge CLK);
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL flush_ghost got %b want 0", OUT_VALID); end
    INSTR = 32'h00400093; IN_VALID = 1'b1; @(negedge CLK);
    IN_VALID = 1'b0;
    n_checks++; if (OUT_VALID !== 1'b1 || IMMExt !== 32'd4) begin
      n_fail++; $display("FAIL flush_next got v=%b %h want v=1 4", OUT_VALID, IMMExt);
    end
  endtask

  task automatic test_reserved();
    @(negedge CLK);
    n_checks++; if (ILLEGAL !== 1'b0) begin n_fail++; $display("FAIL rsvd_pre got %b want 0", ILLEGAL); end
    OUT_READY = 1'b1; INSTR = 32'hFFFFFFFF; IMMSrc = 3'b111; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0; IMMSrc = 3'b000;
    n_checks++; if (OUT_VALID !== 1'b1 || IMMExt !== 32'h0 || ILLEGAL !== 1'b1) begin
      n_fail++; $display("FAIL rsvd got v=%b %h ill=%b want v=1 0 ill=1", OUT_VALID, IMMExt, ILLEGAL);
    end
    FLUSH = 1'b1; @(negedge CLK); FLUSH = 1'b0;
    n_checks++; if (ILLEGAL !== 1'b1) begin n_fail++; $display("FAIL rsvd_flush got %b want 1", ILLEGAL); end
  endtask

  task automatic test_reset_mid();
    OUT_READY = 1'b0; IMMSrc = 3'b000; IN_VALID = 1'b1;
    INSTR = 32'h00800093; @(negedge CLK);
    INSTR = 32'h00900093; @(negedge CLK);
    IN_VALID = 1'b0;
    n_checks++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre got rdy=%b v=%b want rdy=0 v=1", IN_READY, OUT_VALID);
    end
    RST = 1'b1; @(negedge CLK); RST = 1'b0;
    n_checks++; if (OUT_VALID !== 1'b0 || IMMExt !== 32'h0 || IN_READY !== 1'b1 || ILLEGAL !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got v=%b %h rdy=%b ill=%b want v=0 0 rdy=1 ill=0",
                         OUT_VALID, IMMExt, IN_READY, ILLEGAL);
    end
    OUT_READY = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_lost got %b want 0", OUT_VALID); end
  endtask

  initial begin
    test_reset();
    test_formats32();
    test_xlen64();
    test_back_to_back();
    test_flush();
    test_reserved();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
